// File: rtl/gate_truth_checker_if.sv
// Stimulus/result bundle between gate_truth_checker (slave side) and its environment.
// compl_err exists only when GATE_TRUTH_COMPLEMENT_CHECK_EN is defined.
interface gate_truth_checker_if;
    localparam int unsigned ERR_W = 8;
    localparam int unsigned NVEC  = 4;

    logic             start;
    logic             in0;
    logic             in1;
    logic             and_out;
    logic             nand_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [NVEC-1:0]  fail_vec;
`ifdef GATE_TRUTH_COMPLEMENT_CHECK_EN
    logic             compl_err;

    modport master (
        output start, and_out, nand_out,
        input  in0, in1, busy, done, pass, err_count, fail_vec, compl_err
    );
    modport slave (
        input  start, and_out, nand_out,
        output in0, in1, busy, done, pass, err_count, fail_vec, compl_err
    );
`else
    modport master (
        output start, and_out, nand_out,
        input  in0, in1, busy, done, pass, err_count, fail_vec
    );
    modport slave (
        input  start, and_out, nand_out,
        output in0, in1, busy, done, pass, err_count, fail_vec
    );
`endif
endinterface

// File: rtl/gate_truth_checker.sv
// Truth-table sequencer/checker for an AND/NAND gate pair: sweeps (in1,in0)=00..11, samples, counts errors.
// Optional complement check and compl_err output under GATE_TRUTH_COMPLEMENT_CHECK_EN.
module gate_truth_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned NUM_PASSES    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    gate_truth_checker_if.slave   bus
);
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned PASS_W = 4;
    localparam int unsigned VEC_W  = 2;
    localparam int unsigned ERR_W  = 8;
    localparam int unsigned NVEC   = 4;

    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(NUM_PASSES - 1);
    localparam logic [VEC_W-1:0]  VEC_LAST    = '1;

    typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  settle_cnt;
    logic [VEC_W-1:0]  vec;
    logic [PASS_W-1:0] pass_cnt;
    logic [ERR_W-1:0]  err_q;
    logic [NVEC-1:0]   fail_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic              compl_q;

    logic              and_exp;
    logic              exp_miss;
    logic              compl_miss;
    logic              sample_err;
    logic [ERR_W-1:0]  err_inc;

    // Sample verdict; case inequality so X/Z on the gate outputs counts as a failure.
    always_comb begin
        and_exp    = vec[1] & vec[0];
        exp_miss   = (bus.and_out !== and_exp) || (bus.nand_out !== ~and_exp);
`ifdef GATE_TRUTH_COMPLEMENT_CHECK_EN
        compl_miss = (bus.and_out === bus.nand_out);
`else
        compl_miss = 1'b0;
`endif
        sample_err = exp_miss || compl_miss;
        err_inc    = (err_q == '1) ? err_q : err_q + ERR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            vec        <= '0;
            pass_cnt   <= '0;
            err_q      <= '0;
            fail_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            compl_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state      <= HOLD;
                        settle_cnt <= '0;
                        vec        <= '0;
                        pass_cnt   <= '0;
                        err_q      <= '0;
                        fail_q     <= '0;
                        pass_q     <= 1'b0;
                        compl_q    <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                HOLD: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    if (sample_err) begin
                        err_q       <= err_inc;
                        fail_q[vec] <= 1'b1;
                    end
                    if (compl_miss) begin
                        compl_q <= 1'b1;
                    end
                    if (vec != VEC_LAST) begin
                        vec   <= vec + VEC_W'(1);
                        state <= HOLD;
                    end else if (pass_cnt != PASS_LAST) begin
                        vec      <= '0;
                        pass_cnt <= pass_cnt + PASS_W'(1);
                        state    <= HOLD;
                    end else begin
                        // Last vector stays on in0/in1 until the next start.
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= (err_q == '0) && !sample_err;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in0       = vec[0];
    assign bus.in1       = vec[1];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_vec  = fail_q;
`ifdef GATE_TRUTH_COMPLEMENT_CHECK_EN
    assign bus.compl_err = compl_q;
`endif

endmodule
